slice_add_seq: RTL and testbench
================================

SLICE_ADD_SEQ -- requirements
Module: slice_add_seq

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 12, the operand width in bits; legal values are multiples of 3 and at least 3.
REQ-002 The block SHALL define the derived constant N = WIDTH/3, the number of 3-bit slices.
REQ-003 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request a new addition; sampled on the rising clk edge.
REQ-007 a  input  WIDTH  operand A; captured on start acceptance.
REQ-008 b  input  WIDTH  operand B; captured on start acceptance.
REQ-009 cin  input  1  carry-in; captured on start acceptance.
REQ-010 busy  output  1  high while slices are being added.
REQ-011 done  output  1  one-cycle pulse that marks the result as newly valid.
REQ-012 sum  output  WIDTH  registered result.
REQ-013 cout  output  1  registered carry-out of the MSB slice.

Function
REQ-014 The block SHALL implement a three-state FSM with states IDLE, ADD and DONE.
REQ-015 IDLE: start=1 SHALL capture a, b and cin, clear the slice counter, and move to ADD; start=0 SHALL stay in IDLE.
REQ-016 ADD: each cycle SHALL add slice k (bits 3k+2..3k, LSB slice first), using a 3-bit ripple (LSB half-adder stage followed by two full-adder stages) plus the registered carry.
REQ-017 ADD: at the end of each cycle the slice sum SHALL be written into the partial register and the slice carry-out into the carry register; slice 0 SHALL use the captured cin.
REQ-018 ADD: after slice N-1 the FSM SHALL load the partial result into sum, load the final carry into cout, and move to DONE.
REQ-019 DONE: done SHALL be 1 for exactly this cycle; start=1 SHALL be accepted as in IDLE (go to ADD); start=0 SHALL go to IDLE.
REQ-020 busy SHALL be 1 exactly when the state is ADD.
REQ-021 Latency: with start accepted at edge 0, busy SHALL be high in cycles 1..N, done SHALL be high in cycle N+1, and sum/cout SHALL be valid from cycle N+1.
REQ-022 start while busy=1 SHALL be ignored; in-flight operands SHALL NOT change, and no request SHALL be queued.
REQ-023 Changes on a, b or cin after acceptance SHALL NOT affect the in-flight result.
REQ-024 sum and cout SHALL hold the last result until the next completion and SHALL NOT show partial values.
REQ-025 Throughput: back-to-back operation via start in the DONE cycle SHALL give one result every N+1 cycles.
REQ-026 Arithmetic: {cout,sum} SHALL equal (a + b + cin) mod 2^(WIDTH+1).

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for a clock edge, force state IDLE, busy=0, done=0, sum=0, cout=0, and clear the slice counter, carry register and partial register.
REQ-028 Reset asserted mid-operation SHALL abandon the addition, and no done SHALL follow.
REQ-029 After rst_n deasserts, the first start SHALL be accepted on the first rising edge on which rst_n=1.

Verification (WIDTH=12, N=4)
REQ-030 a=0xFFF, b=0x001, cin=0, start pulse -> busy high for 4 cycles, done in cycle 5, sum=0x000, cout=1.
REQ-031 a=0x5A5, b=0x0A5, cin=0 -> sum=0x64A, cout=0; operands changed to 0x000 during busy leave the result unchanged.
REQ-032 a=0xFFF, b=0x000, cin=1 -> sum=0x000, cout=1; then start held high continuously -> next result in cycle 10, with done pulses spaced 5 cycles apart.
REQ-033 start pulses in cycles 2 and 3 of an operation -> ignored, and exactly one done is produced.
REQ-034 rst_n pulsed low in cycle 2 of an operation -> busy=0 and sum=0 immediately; no done follows; the next start with a=0x123, b=0x456 -> sum=0x579, cout=0.

Source files
------------

// File: rtl/slice_add_seq.sv
// slice_add_seq: sequential adder, 3-bit slice per cycle, LSB first.
// Ports: clk, rst_n, start, a, b, cin -> busy, done, sum, cout.
module slice_add_seq #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int N  = WIDTH / 3;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] part;
  logic [WIDTH-1:0] part_nx;
  logic             cy;

  logic [2:0] sa;
  logic [2:0] sb;
  logic [2:0] ss;
  logic       p0;
  logic       g0;
  logic       c1;
  logic       c2;
  logic       sc;

  logic accept;
  logic last;

  // Operand registers shift right each ADD cycle,
  // so the active slice always sits in bits 2:0.
  assign sa = opa[2:0];
  assign sb = opb[2:0];

  // LSB half adder, then the registered carry folds in.
  assign p0    = sa[0] ^ sb[0];
  assign g0    = sa[0] & sb[0];
  assign ss[0] = p0 ^ cy;
  assign c1    = g0 | (p0 & cy);

  assign ss[1] = sa[1] ^ sb[1] ^ c1;
  assign c2    = (sa[1] & sb[1])
               | (c1 & (sa[1] ^ sb[1]));

  assign ss[2] = sa[2] ^ sb[2] ^ c2;
  assign sc    = (sa[2] & sb[2])
               | (c2 & (sa[2] ^ sb[2]));

  // New slice enters at the top; after N
  // shifts slice 0 lands in bits 2:0.
  assign part_nx = (part >> 3)
                 | (WIDTH'(ss) << (WIDTH - 3));

  assign last   = (cnt == CW'(N - 1));
  assign accept = start
                & ((state == IDLE) | (state == DONE));

  assign busy = (state == ADD);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) state_nx = ADD;
      end
      ADD: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        state_nx = start ? ADD : IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      opa  <= '0;
      opb  <= '0;
      part <= '0;
      cy   <= 1'b0;
      sum  <= '0;
      cout <= 1'b0;
    end else if (accept) begin
      opa <= a;
      opb <= b;
      cy  <= cin;
      cnt <= '0;
    end else if (state == ADD) begin
      opa  <= opa >> 3;
      opb  <= opb >> 3;
      cy   <= sc;
      part <= part_nx;
      cnt  <= cnt + 1'b1;
      if (last) begin
        sum  <= part_nx;
        cout <= sc;
      end
    end
  end

endmodule

// File: tb/tb_slice_add_seq.sv
// tb_slice_add_seq: directed + random checks of slice_add_seq
// against a cycle-count reference model of a+b+cin.
module tb_slice_add_seq;

  localparam int W = 12;
  localparam int N = W / 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int errors = 0;
  int checks = 0;

  slice_add_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  // Model: ph=0 idle, 1..N adding, N+1 result cycle.
  int         ph = 0;
  logic [W:0] res = '0;
  logic [W:0] mres = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph   <= 0;
      mres <= '0;
    end else if (ph == 0 || ph == N + 1) begin
      if (start) begin
        ph  <= 1;
        res <= (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
      end else begin
        ph <= 0;
      end
    end else if (ph == N) begin
      ph   <= N + 1;
      mres <= res;
    end else begin
      ph <= ph + 1;
    end
  end

  task automatic check(input string nm,
                       input int act,
                       input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    #2;
    check("busy", int'(busy),
          int'(ph >= 1 && ph <= N));
    check("done", int'(done), int'(ph == N + 1));
    check("sum", int'(sum), int'(mres[W-1:0]));
    check("cout", int'(cout), int'(mres[W]));
  end

  // Caller is just past a negedge.
  task automatic run_op(input logic [W-1:0] ta,
                        input logic [W-1:0] tb,
                        input logic tc,
                        input logic [W-1:0] es,
                        input logic ec,
                        input bit scramble,
                        input bit extra);
    int k;
    int nb;
    int nd;
    start = 1'b1;
    a = ta;
    b = tb;
    cin = tc;
    k = 0;
    nb = 0;
    @(negedge clk);
    k = 1;
    start = 1'b0;
    if (scramble) begin
      a = '0;
      b = '0;
      cin = 1'b0;
    end
    while (!done && k < 20) begin
      if (busy) nb++;
      if (extra) start = (k == 1 || k == 2);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check("latency", k, N + 1);
    check("busy_cycles", nb, N);
    check("res_sum", int'(sum), int'(es));
    check("res_cout", int'(cout), int'(ec));
    nd = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("no_extra_done", nd, 0);
  endtask

  initial begin
    int d1;
    int d2;
    int nd;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_sum", int'(sum), 0);
    check("rst_cout", int'(cout), 0);

    // Start in the same cycle reset releases.
    rst_n = 1'b1;
    run_op(12'hFFF, 12'h001, 1'b0,
           12'h000, 1'b1, 1'b0, 1'b0);
    run_op(12'h5A5, 12'h0A5, 1'b0,
           12'h64A, 1'b0, 1'b1, 1'b0);
    run_op(12'h3C7, 12'h2B9, 1'b1,
           12'h681, 1'b0, 1'b0, 1'b1);

    // Start held high: results every N+1 cycles.
    start = 1'b1;
    a = 12'hFFF;
    b = 12'h000;
    cin = 1'b1;
    d1 = 0;
    d2 = 0;
    nd = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (d1 == 0) d1 = k;
        else if (d2 == 0) d2 = k;
        check("b2b_sum", int'(sum), 0);
        check("b2b_cout", int'(cout), 1);
      end
      if (k == 10) start = 1'b0;
    end
    check("b2b_first", d1, 5);
    check("b2b_second", d2, 10);
    check("b2b_count", nd, 2);

    // Reset in cycle 2 abandons the add.
    start = 1'b1;
    a = 12'h777;
    b = 12'h001;
    cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_sum", int'(sum), 0);
    check("mid_rst_cout", int'(cout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("mid_rst_nodone", nd, 0);
    run_op(12'h123, 12'h456, 1'b0,
           12'h579, 1'b0, 1'b0, 1'b0);

    // Random traffic, occasional reset.
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 2) == 0);
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'($urandom);
      rst_n = ($urandom_range(0, 79) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    start = 1'b0;
    repeat (8) @(negedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
